// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state encoding and stream constants for the boot loader
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_HDR_SEL    = 3'd1,
    ST_HDR_CNT_HI = 3'd2,
    ST_HDR_CNT_LO = 3'd3,
    ST_PAYLOAD    = 3'd4,
    ST_FINISH     = 3'd5
  } boot_state_e;

  localparam logic [7:0] SEL_IMEM = 8'h00;
  localparam logic [7:0] SEL_DMEM = 8'h01;
  localparam logic [7:0] SEL_END  = 8'hFF;

  localparam int TIMEOUT_CYC_DEF = 2_000_000;

endpackage

// File: rtl/boot_timeout_cnt.sv
// rtl/boot_timeout_cnt.sv - saturating idle counter between received bytes
module boot_timeout_cnt
  import boot_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // Holds at LIMIT so a long stall never wraps back into a "fresh" window.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/boot_loader_ctrl.sv
// rtl/boot_loader_ctrl.sv - UART-fed program loader that owns memory and CPU reset
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              cpu_rst_n,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  boot_state_e      state;
  logic [7:0]       cnt_hi;
  logic [23:0]      asm_q;
  logic [1:0]       byte_idx;
  logic [IDX_W-1:0] word_idx;
  logic [IDX_W-1:0] word_cnt;
  logic [IDX_W-1:0] word_nxt;
  logic [15:0]      cnt_n;
  logic             to_clear;
  logic             to_expired;
  logic             timed_out;

  assign cnt_n     = {cnt_hi, rx_byte};
  assign word_nxt  = word_idx + IDX_W'(1);
  assign to_clear  = (state == ST_IDLE) || rx_valid;
  assign timed_out = to_expired && !rx_valid && (state != ST_IDLE);

  boot_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (to_clear),
    .expired(to_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cpu_rst_n <= 1'b1;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt_hi    <= '0;
      asm_q     <= '0;
      byte_idx  <= '0;
      word_idx  <= '0;
      word_cnt  <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_HDR_SEL;
            busy      <= 1'b1;
            cpu_rst_n <= 1'b0;
            err       <= 1'b0;
          end
        end
        ST_FINISH: begin
          done      <= 1'b1;
          cpu_rst_n <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          // Aborts leave cpu_rst_n low so a partial image never executes.
          if (timed_out) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (rx_valid) begin
            case (state)
              ST_HDR_SEL: begin
                if (rx_byte == SEL_END) begin
                  state <= ST_FINISH;
                end else if (rx_byte == SEL_IMEM || rx_byte == SEL_DMEM) begin
                  mem_sel <= rx_byte[0];
                  state   <= ST_HDR_CNT_HI;
                end else begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                end
              end
              ST_HDR_CNT_HI: begin
                cnt_hi <= rx_byte;
                state  <= ST_HDR_CNT_LO;
              end
              ST_HDR_CNT_LO: begin
                if (cnt_n == 16'd0) begin
                  state <= ST_HDR_SEL;
                end else if ({1'b0, cnt_n} > MAX_WORDS) begin
                  err   <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                end else begin
                  word_cnt <= IDX_W'(cnt_n);
                  word_idx <= '0;
                  byte_idx <= '0;
                  state    <= ST_PAYLOAD;
                end
              end
              ST_PAYLOAD: begin
                asm_q    <= {asm_q[15:0], rx_byte};
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                  mem_we    <= 1'b1;
                  mem_wdata <= {asm_q, rx_byte};
                  mem_addr  <= word_idx[ADDR_W-1:0];
                  word_idx  <= word_nxt;
                  if (word_nxt == word_cnt) begin
                    state <= ST_HDR_SEL;
                  end
                end
              end
              default: begin
                state <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb/tb_boot_loader_ctrl.sv - vector table, corner sequences and random streams for boot_loader_ctrl
module tb_boot_loader_ctrl;

  localparam int ADDR_W = 4;
  localparam int TO     = 100;
  localparam int MAXW   = 1 << ADDR_W;

  logic              clock    = 1'b0;
  logic              reset    = 1'b0;
  logic              start    = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_byte  = 8'h00;
  logic              cpu_rst_n;
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;

  boot_loader_ctrl #(
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .cpu_rst_n(cpu_rst_n),
    .mem_we   (mem_we),
    .mem_sel  (mem_sel),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clock = ~clock;

  int          n_vec    = 0;
  int          n_mis    = 0;
  int          done_cnt = 0;
  int          exp_res;
  logic [7:0]  stream[$];
  logic [36:0] got[$];
  logic [36:0] exp_w[$];

  typedef struct {
    logic [127:0] bytes;
    int           len;
    int           nwr;
    logic [36:0]  first;
    logic [36:0]  last;
    logic         ok;
  } vec_t;

  vec_t tbl[6];

  always @(negedge clock) begin
    if (mem_we) got.push_back({mem_sel, mem_addr, mem_wdata});
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: parse the stream as segments; exp_res 0 = clean end, 1 = abort.
  function automatic void model();
    int p = 0;
    int n;
    logic [7:0] s;
    logic [31:0] w;
    exp_w.delete();
    exp_res = 1;
    while (1) begin
      if (p >= stream.size()) return;
      s = stream[p];
      p++;
      if (s == 8'hFF) begin
        exp_res = 0;
        return;
      end
      if (s > 8'h01) return;
      if (p + 2 > stream.size()) return;
      n = int'({stream[p], stream[p+1]});
      p += 2;
      if (n > MAXW) return;
      for (int k = 0; k < n; k++) begin
        if (p + 4 > stream.size()) return;
        w = {stream[p], stream[p+1], stream[p+2], stream[p+3]};
        p += 4;
        exp_w.push_back({s[0], ADDR_W'(k), w});
      end
    end
  endfunction

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_load(input int gap_max, input string tag);
    int k;
    got.delete();
    done_cnt = 0;
    pulse_start();
    check({tag, ".busy_rise"}, {busy, cpu_rst_n, err}, 3'b100);
    foreach (stream[i]) begin
      send(stream[i]);
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clock);
    end
    k = 0;
    while (busy && k < 4 * TO) begin
      @(negedge clock);
      k++;
    end
    check({tag, ".finished"}, busy, 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".nwr"}, got.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got.size(); i++)
      check({tag, ".wr"}, got[i], exp_w[i]);
    check({tag, ".done"}, done_cnt, (exp_res == 0) ? 1 : 0);
    check({tag, ".flags"}, {busy, err, cpu_rst_n}, (exp_res == 0) ? 3'b001 : 3'b010);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{bytes: {96'h000002DEADBEEF01234567FF, 32'h0}, len: 12, nwr: 2,
               first: {1'b0, 4'd0, 32'hDEADBEEF}, last: {1'b0, 4'd1, 32'h01234567}, ok: 1'b1};
    tbl[1] = '{bytes: {120'h000001112233440100010000002AFF, 8'h0}, len: 15, nwr: 2,
               first: {1'b0, 4'd0, 32'h11223344}, last: {1'b1, 4'd0, 32'h0000002A}, ok: 1'b1};
    tbl[2] = '{bytes: {8'h07, 120'h0}, len: 1, nwr: 0, first: '0, last: '0, ok: 1'b0};
    tbl[3] = '{bytes: {32'h000000FF, 96'h0}, len: 4, nwr: 0, first: '0, last: '0, ok: 1'b1};
    tbl[4] = '{bytes: {24'h010011, 104'h0}, len: 3, nwr: 0, first: '0, last: '0, ok: 1'b0};
    tbl[5] = '{bytes: {8'hFF, 120'h0}, len: 1, nwr: 0, first: '0, last: '0, ok: 1'b1};

    repeat (2) @(negedge clock);
    check("reset_vals", {cpu_rst_n, mem_we, mem_sel, mem_addr, mem_wdata, busy, done, err},
          {1'b1, 41'd0});
    reset = 1'b1;
    @(negedge clock);

    for (int v = 0; v < 6; v++) begin
      stream.delete();
      for (int i = 0; i < tbl[v].len; i++) stream.push_back(tbl[v].bytes[127-8*i -: 8]);
      run_load(0, "tbl");
      check("tbl.nwr", got.size(), tbl[v].nwr);
      if (tbl[v].nwr > 0 && got.size() > 0) begin
        check("tbl.first", got[0], tbl[v].first);
        check("tbl.last", got[got.size()-1], tbl[v].last);
      end
      check("tbl.done", done_cnt, tbl[v].ok ? 1 : 0);
      check("tbl.flags", {busy, err, cpu_rst_n}, tbl[v].ok ? 3'b001 : 3'b010);
    end

    // Write strobe and done latency, with a start pulse issued mid-load.
    got.delete();
    done_cnt = 0;
    pulse_start();
    send(8'h00); send(8'h00); send(8'h01);
    send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
    check("we_cycle", {mem_we, mem_sel, mem_addr, mem_wdata}, {1'b1, 1'b0, 4'd0, 32'hA1B2C3D4});
    @(negedge clock);
    check("we_one_cycle", mem_we, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_ignored", {busy, cpu_rst_n, err}, 3'b100);
    send(8'hFF);
    check("done_not_yet", {done, busy, cpu_rst_n}, 3'b010);
    @(negedge clock);
    check("done_pulse", {done, busy, cpu_rst_n}, 3'b101);
    @(negedge clock);
    check("done_drop", done, 0);
    check("seq_writes", got.size(), 1);

    // Stall after two payload bytes: error exactly TO cycles after the last byte.
    got.delete();
    pulse_start();
    send(8'h00); send(8'h00); send(8'h01); send(8'h11); send(8'h22);
    repeat (TO - 1) @(negedge clock);
    check("timeout_early", {err, busy}, 2'b01);
    @(negedge clock);
    check("timeout_hit", {err, busy, cpu_rst_n}, 3'b100);
    check("timeout_nowr", got.size(), 0);

    // Asynchronous reset in the middle of a dmem payload word.
    pulse_start();
    send(8'h01); send(8'h00); send(8'h02);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h05); send(8'h06);
    #2 reset = 1'b0;
    #1;
    check("async_reset", {cpu_rst_n, mem_we, mem_sel, mem_addr, mem_wdata, busy, done, err},
          {1'b1, 41'd0});
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Largest legal segment, N = 2^ADDR_W.
    stream.delete();
    stream.push_back(8'h01);
    stream.push_back(8'h00);
    stream.push_back(8'(MAXW));
    for (int i = 0; i < 4 * MAXW; i++) stream.push_back(8'($urandom));
    stream.push_back(8'hFF);
    model();
    run_load(1, "maxn");
    compare_model("maxn");

    for (int it = 0; it < 25; it++) begin
      int nseg;
      int n;
      bit term;
      stream.delete();
      term = 1'b1;
      nseg = $urandom_range(3, 0);
      for (int s = 0; s < nseg && term; s++) begin
        if ($urandom_range(19, 0) == 0) begin
          stream.push_back(8'($urandom_range(254, 2)));
          term = 1'b0;
        end else begin
          case ($urandom_range(9, 0))
            0:       n = 0;
            1:       n = MAXW;
            2:       n = MAXW + 1;
            default: n = $urandom_range(3, 1);
          endcase
          stream.push_back(8'($urandom_range(1, 0)));
          stream.push_back(8'(n >> 8));
          stream.push_back(8'(n));
          if (n > MAXW) term = 1'b0;
          else for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
        end
      end
      if (term) begin
        if ($urandom_range(4, 0) == 0) begin
          repeat ($urandom_range(3, 0)) if (stream.size() > 0) void'(stream.pop_back());
        end else begin
          stream.push_back(8'hFF);
        end
      end
      model();
      run_load($urandom_range(2, 0), "rand");
      compare_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/boot_loader_ctrl.md
# boot_loader_ctrl

Program-load controller that takes over the instruction and data memories from the CPU and writes them from a UART byte stream. It sits beside the CPU top level, between the UART receiver and the memory write ports. While loading it holds the CPU in reset, and it releases the CPU only after a complete, error-free image has been written. The block sequences the datapath: it decides who owns memory and when the processor runs.

## Interface
- `ADDR_W`, 14: word-address width of each memory; max words per segment = 2^ADDR_W.
- `TIMEOUT_CYC`, 2_000_000: idle cycles between bytes before a load aborts.
- `clock`  in  1  system clock (the CPU clock domain).
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  load request, sampled in IDLE; already synchronized and debounced upstream.
- `rx_valid`  in  1  one-cycle strobe; `rx_byte` is valid.
- `rx_byte`  in  8  received byte.
- `cpu_rst_n`  out  1  active-low hold for fetch, decode and register file.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_sel`  out  1  0 = instruction memory, 1 = data memory.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  word to write.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  sticky error flag; cleared on the next accepted `start`.

## Operation
- Stream format, repeated as segments:
  - SEL byte: 0x00 selects imem, 0x01 selects dmem, 0xFF ends the image.
  - CNT_HI and CNT_LO bytes: 16-bit word count N.
  - Payload: 4·N bytes. Each word arrives MSB first and is written at addresses 0..N-1 of the selected memory.
- States: IDLE, HDR_SEL, HDR_CNT_HI, HDR_CNT_LO, PAYLOAD, FINISH.
- IDLE:
  - `start`=1 → HDR_SEL.
  - Set `busy`=1, `cpu_rst_n`=0, clear `err`, zero the timeout counter.
- HDR_SEL, on `rx_valid`:
  - 0x00 or 0x01 → latch `mem_sel`, go to HDR_CNT_HI.
  - 0xFF → FINISH.
  - Any other value → error.
- HDR_CNT_HI → HDR_CNT_LO.
- HDR_CNT_LO:
  - N=0 → HDR_SEL.
  - N > 2^ADDR_W → error.
  - Otherwise → PAYLOAD with word index 0 and byte index 0.
- PAYLOAD:
  - Each byte shifts into a 24-bit assembly register and increments the 2-bit byte index.
  - On the 4th byte, register `mem_wdata` = {assembly, rx_byte}, `mem_addr` = word index, and pulse `mem_we`.
  - After that write, the word index increments. When it reaches N → HDR_SEL; otherwise stay in PAYLOAD.
- FINISH: pulse `done`, set `cpu_rst_n`=1 and `busy`=0, → IDLE.
- Error (bad SEL, oversize N, or timeout): `err`=1, `busy`=0 → IDLE. `cpu_rst_n` stays 0, so a partial image never runs; only a later successful load releases it.
- Timeout counter:
  - Runs in every non-IDLE state and zeroes on each `rx_valid`.
  - Reaching TIMEOUT_CYC-1 with no byte is an error.
  - Saturates; no wrap-around.
- `start` is ignored while `busy`.
- `rx_valid` in IDLE or FINISH is dropped.

## Timing
- Reset values: `cpu_rst_n`=1 (CPU runs the existing image), `mem_we`=0, `mem_sel`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0; state IDLE.
- `busy` rises and `cpu_rst_n` falls one cycle after `start` is sampled.
- `mem_we` is high exactly one cycle: the cycle after the 4th payload byte's `rx_valid`. `mem_addr`, `mem_wdata` and `mem_sel` are stable during that cycle.
- A new `rx_valid` in the `mem_we` cycle is accepted normally, so back-to-back strobes are lossless.
- `done` and the rise of `cpu_rst_n` both occur two cycles after the 0xFF byte's `rx_valid` (FINISH state, then outputs register).
- The 16-bit count compare against 2^ADDR_W is done on the full 17-bit range.
- The word index is ADDR_W+1 bits wide so that N = 2^ADDR_W terminates correctly.
- Asynchronous reset mid-load: all outputs return to their reset values immediately. Memory may be partially written; this is documented behaviour, and software must reload.

## Structure
- Shared package `boot_pkg`:
  - state enum;
  - constants `SEL_IMEM`=8'h00, `SEL_DMEM`=8'h01, `SEL_END`=8'hFF;
  - default TIMEOUT_CYC.
- One sub-module: `boot_timeout_cnt`, a saturating idle counter with a clear input and an `expired` output.
- Top-level integration: the memory write muxes select the loader port whenever `busy`=1.

## Test plan
- Segment load: `start`; 00,00,02, DE,AD,BE,EF, 01,23,45,67, FF → imem[0]=DEADBEEF, imem[1]=01234567; `done` pulses once; `cpu_rst_n` returns to 1.
- Two segments: imem N=1, then dmem N=1 (00,00,00,2A), then FF → dmem[0]=0000002A; `mem_sel`=1 on the second write only.
- Bad SEL byte 0x07 → `err`=1, `busy`=0, `cpu_rst_n` stays 0, no `mem_we`; a following clean load clears `err`.
- Timeout: stop after 2 payload bytes with TIMEOUT_CYC=100 → `err` set at cycle 100 after the last byte, no write issued.
- N=0 segment, then FF → no `mem_we`, `done` pulses.
- Async reset asserted mid-payload → all outputs at reset values in the same cycle; `start` during `busy` produces no state change.
